// File: rtl/rv32_m_ext_unit.sv
// RV32M execution unit: iterative shift-add multiplier and restoring divider
// behind a start/ack handshake with the EX stage.
module rv32_m_ext_unit #(
    parameter int XLEN         = 32,
    parameter int FAST_SPECIAL = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [2:0]      i_f3,
    output logic [XLEN-1:0] o_res,
    output logic            o_ack,
    output logic            o_busy
);

    localparam int                CW      = $clog2(XLEN);
    localparam logic [CW-1:0]     LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0]   ONES    = '1;
    localparam logic [XLEN-1:0]   MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     count;
    logic [2:0]        f3;
    logic [XLEN-1:0]   a_abs;
    logic [XLEN-1:0]   b_abs;
    logic              res_neg;
    logic              rem_neg;
    logic [2*XLEN-1:0] acc;      // product, or dividend/quotient shift register in acc[XLEN-1:0]
    logic [XLEN-1:0]   rem;

    // Start-time decode of the incoming operation
    logic            a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_abs_in, b_abs_in, fast_res;

    always_comb begin
        a_neg    = i_rs1[XLEN-1] && (i_f3 == 3'b001 || i_f3 == 3'b010 ||
                                     i_f3 == 3'b100 || i_f3 == 3'b110);
        b_neg    = i_rs2[XLEN-1] && (i_f3 == 3'b001 || i_f3 == 3'b100 || i_f3 == 3'b110);
        a_abs_in = a_neg ? -i_rs1 : i_rs1;
        b_abs_in = b_neg ? -i_rs2 : i_rs2;
        div_zero = i_f3[2] && (i_rs2 == '0);
        div_ovf  = i_f3[2] && !i_f3[0] && (i_rs1 == MIN_NEG) && (i_rs2 == ONES);
        if (div_zero) fast_res = i_f3[1] ? i_rs1 : ONES;
        else          fast_res = i_f3[1] ? '0 : i_rs1;
    end

    // One iteration of the multiply or divide datapath
    logic [2*XLEN-1:0] mul_addend;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;

    always_comb begin
        mul_addend = {{XLEN{1'b0}}, a_abs} << count;
        div_shift  = {rem, acc[XLEN-1]};
        div_ge     = div_shift >= {1'b0, b_abs};
        // Low bits suffice: when the trial subtract succeeds the difference is below b_abs.
        div_diff   = div_shift[XLEN-1:0] - b_abs;
    end

    // Sign fix-up and result selection
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, remv, fix_res;

    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        fix_res = '0;
        prod    = res_neg ? -acc : acc;
        quot    = res_neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        remv    = rem_neg ? -rem : rem;
        case (f3)
            3'b000:                 fix_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quot;
            default:                fix_res = remv;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= IDLE;
            count   <= '0;
            f3      <= '0;
            a_abs   <= '0;
            b_abs   <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            acc     <= '0;
            rem     <= '0;
            o_res   <= '0;
            o_ack   <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            o_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_en) begin
                        f3      <= i_f3;
                        a_abs   <= a_abs_in;
                        b_abs   <= b_abs_in;
                        rem_neg <= a_neg;
                        rem     <= '0;
                        count   <= '0;
                        o_busy  <= 1'b1;
                        if (i_f3[2]) begin
                            acc     <= {{XLEN{1'b0}}, a_abs_in};
                            // x/0 must yield all ones regardless of dividend sign
                            res_neg <= (a_neg ^ b_neg) && !div_zero;
                        end else begin
                            acc     <= '0;
                            res_neg <= a_neg ^ b_neg;
                        end
                        if (FAST_SPECIAL != 0 && (div_zero || div_ovf)) begin
                            o_res <= fast_res;
                            o_ack <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (f3[2]) begin
                        rem             <= div_ge ? div_diff : div_shift[XLEN-1:0];
                        acc[XLEN-1:0]   <= {acc[XLEN-2:0], div_ge};
                    end else if (b_abs[count]) begin
                        acc <= acc + mul_addend;
                    end
                    count <= count + 1'b1;
                    if (count == LAST) state <= FIX;
                end
                FIX: begin
                    o_res <= fix_res;
                    o_ack <= 1'b1;
                    state <= DONE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_m_ext_unit.sv
// Scoreboard bench for rv32_m_ext_unit: one fast-special and one full-iteration
// instance share stimulus; a reference model predicts results and ack latency.
module tb_rv32_m_ext_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] res_f, res_s;
    logic        ack_f, ack_s, busy_f, busy_s;

    always #5 clk = ~clk;

    rv32_m_ext_unit #(.XLEN(32), .FAST_SPECIAL(1)) dut_fast (
        .i_clk(clk), .i_rst(rst_n), .i_en(en), .i_rs1(rs1), .i_rs2(rs2), .i_f3(f3),
        .o_res(res_f), .o_ack(ack_f), .o_busy(busy_f)
    );

    rv32_m_ext_unit #(.XLEN(32), .FAST_SPECIAL(0)) dut_slow (
        .i_clk(clk), .i_rst(rst_n), .i_en(en), .i_rs1(rs1), .i_rs2(rs2), .i_f3(f3),
        .o_res(res_s), .o_ack(ack_s), .o_busy(busy_s)
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t0;
        int          id;
    } exp_t;

    exp_t q_f[$];
    exp_t q_s[$];
    exp_t ef, es;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   cyc       = 0;
    int   starts    = 0;
    int   exp_acks  = 0;
    int   acks_f    = 0;
    int   acks_s    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b};      return p[31:0];  end
            3'd1: begin p = sa * sb;                      return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b});    return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b};      return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a;             p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a;          return a % b; end
        endcase
    endfunction

    // Pop and compare on every ack; an ack with nothing outstanding is an error.
    always @(negedge clk) begin
        if (ack_f) begin
            acks_f++;
            if (q_f.size() == 0) check("fast unexpected ack", 32'd1, 32'd0);
            else begin
                ef = q_f.pop_front();
                check($sformatf("op%0d fast result", ef.id), res_f, ef.res);
                check($sformatf("op%0d fast latency", ef.id), 32'(cyc - ef.t0), 32'(ef.lat));
                check($sformatf("op%0d fast busy at ack", ef.id), {31'b0, busy_f}, 32'd1);
            end
        end
        if (ack_s) begin
            acks_s++;
            if (q_s.size() == 0) check("slow unexpected ack", 32'd1, 32'd0);
            else begin
                es = q_s.pop_front();
                check($sformatf("op%0d slow result", es.id), res_s, es.res);
                check($sformatf("op%0d slow latency", es.id), 32'(cyc - es.t0), 32'(es.lat));
                check($sformatf("op%0d slow busy at ack", es.id), {31'b0, busy_s}, 32'd1);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        exp_t e;
        logic special;
        @(negedge clk);
        rs1 = a; rs2 = b; f3 = f; en = 1'b1;
        special = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        e.res = model(a, b, f);
        e.t0  = cyc;
        e.id  = starts;
        starts++;
        exp_acks++;
        e.lat = special ? 1 : 34;
        q_f.push_back(e);
        e.lat = 34;
        q_s.push_back(e);
        @(negedge clk);
        en  = 1'b0;
        rs1 = $urandom;
        rs2 = $urandom;
        f3  = 3'($urandom_range(0, 7));
        check($sformatf("op%0d fast busy after start", e.id), {31'b0, busy_f}, 32'd1);
        check($sformatf("op%0d slow busy after start", e.id), {31'b0, busy_s}, 32'd1);
    endtask

    // Returns on the edge that ends the last ack cycle, so a following issue is back-to-back.
    task automatic wait_done();
        int n;
        n = 0;
        while ((q_f.size() != 0 || q_s.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) begin
            check("ack timeout outstanding", 32'(q_f.size() + q_s.size()), 32'd0);
            q_f.delete();
            q_s.delete();
        end
    endtask

    localparam int ND = 13;
    logic [31:0] d_a [ND] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'h1234_5678, 32'd5, 32'h8000_0000, 32'h8000_0000,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h0000_ABCD, 32'd7};
    logic [31:0] d_b [ND] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd2, 32'd2, 32'd7, 32'h10, 32'hFFFF_FFFE};
    logic [2:0]  d_f [ND] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd7, 3'd4, 3'd6,
                              3'd4, 3'd6, 3'd5, 3'd7, 3'd6};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;
        rst_n = 1'b0; en = 1'b0; rs1 = '0; rs2 = '0; f3 = '0;
        repeat (3) @(negedge clk);
        check("reset fast res",  res_f, 32'd0);
        check("reset slow res",  res_s, 32'd0);
        check("reset fast ack",  {31'b0, ack_f},  32'd0);
        check("reset slow ack",  {31'b0, ack_s},  32'd0);
        check("reset fast busy", {31'b0, busy_f}, 32'd0);
        check("reset slow busy", {31'b0, busy_s}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < ND; i++) begin
            issue(d_a[i], d_b[i], d_f[i]);
            wait_done();
        end

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            issue(ra, rb, 3'($urandom_range(0, 7)));
            wait_done();
        end

        // A start while busy must be ignored; a divide-by-zero would ack early if accepted.
        issue(32'h0001_2345, 32'h0000_0321, 3'd0);
        repeat (4) @(negedge clk);
        en = 1'b1; rs1 = 32'hDEAD_BEEF; rs2 = 32'd0; f3 = 3'd4;
        @(negedge clk);
        en = 1'b0;
        wait_done();

        // Reset during a divide aborts it with no ack.
        issue(32'h1234_5678, 32'd5, 3'd4);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        exp_acks -= q_s.size();
        q_f.delete();
        q_s.delete();
        #1;
        check("abort fast res",  res_f, 32'd0);
        check("abort slow res",  res_s, 32'd0);
        check("abort fast busy", {31'b0, busy_f}, 32'd0);
        check("abort slow busy", {31'b0, busy_s}, 32'd0);
        check("abort fast ack",  {31'b0, ack_f},  32'd0);
        check("abort slow ack",  {31'b0, ack_s},  32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issue(32'hFFFF_FF00, 32'd3, 3'd4);
        wait_done();
        issue(32'hFFFF_FF00, 32'd3, 3'd6);
        wait_done();

        repeat (40) @(negedge clk);
        check("fast ack count", 32'(acks_f), 32'(exp_acks));
        check("slow ack count", 32'(acks_s), 32'(exp_acks));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
